// File: rtl/trace_pkg.sv
// Shared types and trigger-mode encodings for the pipeline trace buffer.
package trace_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } trace_state_e;

    localparam logic [1:0] TRIG_EXT   = 2'b00;
    localparam logic [1:0] TRIG_PC    = 2'b01;
    localparam logic [1:0] TRIG_NOW   = 2'b10;
    localparam logic [1:0] TRIG_NEVER = 2'b11;

endpackage

// File: rtl/trace_trigger_detect.sv
// Trigger source selection: registered rising edge of trig_in, same-cycle
// PC match on channel 0, immediate, or never.
module trace_trigger_detect
    import trace_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [1:0]        i_trig_mode,
    input  logic              i_trig_in,
    input  logic [DATA_W-1:0] i_trig_pc,
    input  logic              i_pc_valid,
    input  logic [DATA_W-1:0] i_pc,
    output logic              o_trig_hit
);

    logic r_trig_q;

    // Previous-cycle copy of trig_in for rising-edge detection
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_trig_q <= 1'b0;
        else          r_trig_q <= i_trig_in;
    end

    // Mode mux; the PC match only counts when channel 0 carries a valid word
    always_comb begin
        o_trig_hit = 1'b0;
        case (i_trig_mode)
            TRIG_EXT:   o_trig_hit = i_trig_in & ~r_trig_q;
            TRIG_PC:    o_trig_hit = i_pc_valid && (i_pc == i_trig_pc);
            TRIG_NOW:   o_trig_hit = 1'b1;
            TRIG_NEVER: o_trig_hit = 1'b0;
            default:    o_trig_hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/pipeline_trace_buffer.sv
// Circular trace capture of per-stage pipeline channels with an
// arm/trigger/post-trigger window, drained oldest-first over valid/ready.
module pipeline_trace_buffer
    import trace_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int NUM_CH = 5,
    parameter  int DEPTH  = 64,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_arm,
    input  logic                     i_abort,
    input  logic                     i_filter_en,
    input  logic [1:0]               i_trig_mode,
    input  logic                     i_trig_in,
    input  logic [DATA_W-1:0]        i_trig_pc,
    input  logic [AW-1:0]            i_post_count,
    input  logic [NUM_CH-1:0]        i_sample_valid,
    input  logic [NUM_CH*DATA_W-1:0] i_sample_data,
    output logic                     o_rd_valid,
    input  logic                     i_rd_ready,
    output logic [NUM_CH*DATA_W-1:0] o_rd_data,
    output logic [NUM_CH-1:0]        o_rd_mask,
    output logic                     o_rd_last,
    output logic [1:0]               o_state,
    output logic                     o_wrapped,
    output logic [AW:0]              o_entry_count
);

    localparam int            ENT_W    = NUM_CH * (DATA_W + 1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    trace_state_e        r_state, w_state_nxt;
    logic [AW-1:0]       r_wr_ptr, r_rd_ptr, r_post_cnt;
    logic [AW:0]         r_count;
    logic                r_wrapped;
    logic [ENT_W-1:0]    r_mem [DEPTH];

    logic                w_trig_hit, w_qual, w_store, w_xfer, w_full;
    logic                w_wrapped_nxt, w_flush;
    logic [AW-1:0]       w_wr_ptr_nxt;

    trace_trigger_detect #(.DATA_W(DATA_W)) u_trig (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_trig_mode (i_trig_mode),
        .i_trig_in   (i_trig_in),
        .i_trig_pc   (i_trig_pc),
        .i_pc_valid  (i_sample_valid[0]),
        .i_pc        (i_sample_data[DATA_W-1:0]),
        .o_trig_hit  (w_trig_hit)
    );

    // Qualification, store decision and look-ahead pointer/wrap values
    always_comb begin
        w_qual  = !i_filter_en || (|i_sample_valid);
        w_store = 1'b0;
        if (!i_abort) begin
            case (r_state)
                ARMED:   w_store = w_qual || w_trig_hit;  // trigger sample bypasses the filter
                POST:    w_store = w_qual;
                default: w_store = 1'b0;
            endcase
        end
        w_full        = (r_count == FULL_CNT);
        w_wr_ptr_nxt  = w_store ? r_wr_ptr + 1'b1 : r_wr_ptr;
        w_wrapped_nxt = r_wrapped | (w_store & w_full);
        w_xfer        = o_rd_valid && i_rd_ready;
        w_flush       = i_abort || (w_xfer && o_rd_last);
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic; abort overrides everything, including a same-cycle arm
    always_comb begin
        w_state_nxt = r_state;
        if (i_abort) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:  if (i_arm) w_state_nxt = ARMED;
                ARMED: if (w_trig_hit)
                           w_state_nxt = (i_post_count == '0) ? DONE : POST;
                POST:  if (w_store && r_post_cnt == AW'(1)) w_state_nxt = DONE;
                DONE:  if (w_xfer && o_rd_last) w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Readout handshake outputs
    always_comb begin
        o_rd_valid = (r_state == DONE) && (r_count != '0);
        o_rd_last  = o_rd_valid && (r_count == (AW+1)'(1));
    end

    // Pointers, occupancy, wrap flag and post-trigger countdown
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_wrapped  <= 1'b0;
            r_post_cnt <= '0;
        end else if (w_flush) begin
            // Every return to IDLE leaves a clean slate so the next window starts at entry 0
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_wrapped  <= 1'b0;
            r_post_cnt <= '0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= w_wr_ptr_nxt;
                if (w_full) r_wrapped <= 1'b1;
                else        r_count   <= r_count + 1'b1;
            end
            // post_count is AW bits wide, so it can never exceed DEPTH-1
            if (r_state == ARMED && w_trig_hit)
                r_post_cnt <= i_post_count;
            else if (r_state == POST && w_store)
                r_post_cnt <= r_post_cnt - 1'b1;
            // Oldest entry sits at the write pointer once the ring has wrapped
            if (r_state != DONE && w_state_nxt == DONE) begin
                r_rd_ptr <= w_wrapped_nxt ? w_wr_ptr_nxt : '0;
            end else if (w_xfer) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count  <= r_count - 1'b1;
            end
        end
    end

    // Sample storage; contents are don't-care after reset
    always_ff @(posedge i_clk) begin
        if (w_store) r_mem[r_wr_ptr] <= {i_sample_valid, i_sample_data};
    end

    assign o_rd_data     = r_mem[r_rd_ptr][NUM_CH*DATA_W-1:0];
    assign o_rd_mask     = r_mem[r_rd_ptr][ENT_W-1 -: NUM_CH];
    assign o_state       = r_state;
    assign o_wrapped     = r_wrapped;
    assign o_entry_count = r_count;

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Directed bench for pipeline_trace_buffer (DEPTH=8, two 16-bit channels).
module tb_pipeline_trace_buffer;

    localparam int DATA_W = 16;
    localparam int NUM_CH = 2;
    localparam int DEPTH  = 8;
    localparam int AW     = 3;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     arm, abort, filter_en, trig_in, rd_ready;
    logic [1:0]               trig_mode;
    logic [DATA_W-1:0]        trig_pc;
    logic [AW-1:0]            post_count;
    logic [NUM_CH-1:0]        sample_valid;
    logic [NUM_CH*DATA_W-1:0] sample_data;
    logic                     rd_valid, rd_last, wrapped;
    logic [NUM_CH*DATA_W-1:0] rd_data;
    logic [NUM_CH-1:0]        rd_mask;
    logic [1:0]               state;
    logic [AW:0]              entry_count;

    int n_chk = 0;
    int n_err = 0;

    // expected window, oldest first
    logic [15:0] e_pc [16];
    logic [1:0]  e_m  [16];
    int          e_n;

    pipeline_trace_buffer #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_arm(arm), .i_abort(abort),
        .i_filter_en(filter_en), .i_trig_mode(trig_mode), .i_trig_in(trig_in),
        .i_trig_pc(trig_pc), .i_post_count(post_count),
        .i_sample_valid(sample_valid), .i_sample_data(sample_data),
        .o_rd_valid(rd_valid), .i_rd_ready(rd_ready), .o_rd_data(rd_data),
        .o_rd_mask(rd_mask), .o_rd_last(rd_last), .o_state(state),
        .o_wrapped(wrapped), .o_entry_count(entry_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ch0 carries the PC-like word, ch1 a derived word so both lanes are checked
    function automatic logic [31:0] mkdat(input logic [15:0] pc);
        return {pc ^ 16'hA5A5, pc};
    endfunction

    task automatic put(input logic [1:0] v, input logic [15:0] pc);
        sample_valid = v;
        sample_data  = mkdat(pc);
    endtask

    task automatic do_arm();
        arm = 1'b1;
        cyc();
        arm = 1'b0;
    endtask

    task automatic expect_add(input logic [15:0] pc, input logic [1:0] m);
        e_pc[e_n] = pc;
        e_m[e_n]  = m;
        e_n++;
    endtask

    // Drain the window, checking every cycle the entry is presented (stalled or not)
    task automatic drain(input string tag, input bit rnd);
        int idx = 0;
        int guard = 0;
        while (idx < e_n && guard < 200) begin
            rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            chk($sformatf("%s_vld%0d", tag, idx), rd_valid, 1'b1);
            chk($sformatf("%s_dat%0d", tag, idx), rd_data, mkdat(e_pc[idx]));
            chk($sformatf("%s_msk%0d", tag, idx), rd_mask, e_m[idx]);
            chk($sformatf("%s_lst%0d", tag, idx), rd_last, (idx == e_n - 1));
            cyc();
            if (rd_ready) idx++;
            guard++;
        end
        rd_ready = 1'b0;
        chk({tag, "_drained"}, idx, e_n);
        chk({tag, "_idle"}, state, 2'd0);
        chk({tag, "_vld_end"}, rd_valid, 1'b0);
        chk({tag, "_cnt_end"}, entry_count, 0);
        chk({tag, "_wrap_end"}, wrapped, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; arm = 0; abort = 0; filter_en = 0; trig_in = 0; rd_ready = 0;
        trig_mode = 2'b11; trig_pc = '0; post_count = '0;
        sample_valid = '0; sample_data = '0;
        #23;
        chk("rst_state", state, 2'd0);
        chk("rst_cnt", entry_count, 0);
        chk("rst_vld", rd_valid, 1'b0);
        chk("rst_last", rd_last, 1'b0);
        chk("rst_wrap", wrapped, 1'b0);
        rst_n = 1'b1;
        cyc();

        // 1: ext edge trigger after 3 stores, post_count=2 -> 6 entries
        trig_mode = 2'b00; post_count = 3'd2; put(2'b11, 16'h0);
        do_arm();
        chk("t1_armed", state, 2'd1);
        e_n = 0;
        for (int i = 0; i < 3; i++) begin
            put(2'b11, 16'h10 + 16'(i)); expect_add(16'h10 + 16'(i), 2'b11); cyc();
        end
        trig_in = 1'b1; put(2'b11, 16'h13); expect_add(16'h13, 2'b11); cyc();
        chk("t1_post", state, 2'd2);
        trig_in = 1'b0;
        put(2'b11, 16'h14); expect_add(16'h14, 2'b11); cyc();
        put(2'b11, 16'h15); expect_add(16'h15, 2'b11); cyc();
        chk("t1_done", state, 2'd3);
        chk("t1_cnt", entry_count, 6);
        chk("t1_wrap", wrapped, 1'b0);
        drain("t1", 1'b0);

        // 2: 20 ARMED stores, then immediate trigger, post_count=3 -> wrapped
        trig_mode = 2'b11; post_count = 3'd3;
        do_arm();
        for (int k = 0; k < 20; k++) begin
            put(2'b11, 16'h100 + 16'(k)); cyc();
        end
        chk("t2_armed", state, 2'd1);
        chk("t2_cnt_sat", entry_count, 8);
        chk("t2_wrap_arm", wrapped, 1'b1);
        trig_mode = 2'b10;
        put(2'b11, 16'h200); cyc();
        chk("t2_post", state, 2'd2);
        trig_mode = 2'b11;
        for (int k = 1; k < 4; k++) begin
            put(2'b11, 16'h200 + 16'(k)); cyc();
        end
        chk("t2_done", state, 2'd3);
        chk("t2_cnt", entry_count, 8);
        chk("t2_wrap", wrapped, 1'b1);
        e_n = 0;
        for (int k = 0; k < 4; k++) expect_add(16'h110 + 16'(k), 2'b11);
        for (int k = 0; k < 4; k++) expect_add(16'h200 + 16'(k), 2'b11);
        drain("t2", 1'b0);

        // 3: filter on, odd cycles valid, PC match 0x40 on an even cycle
        filter_en = 1'b1; trig_mode = 2'b01; trig_pc = 16'h40; post_count = 3'd2;
        do_arm();
        e_n = 0;
        put(2'b00, 16'h40); cyc();                                  // invalid ch0: no match, no store
        chk("t3_nomatch", state, 2'd1);
        chk("t3_nostore", entry_count, 0);
        put(2'b11, 16'h31); expect_add(16'h31, 2'b11); cyc();
        put(2'b00, 16'h32); cyc();
        put(2'b11, 16'h33); expect_add(16'h33, 2'b11); cyc();
        put(2'b00, 16'h34); cyc();
        put(2'b11, 16'h35); expect_add(16'h35, 2'b11); cyc();
        put(2'b01, 16'h40); expect_add(16'h40, 2'b01); cyc();       // trigger
        chk("t3_post", state, 2'd2);
        put(2'b11, 16'h37); expect_add(16'h37, 2'b11); cyc();
        put(2'b00, 16'h38); cyc();
        chk("t3_post_skip", state, 2'd2);
        put(2'b11, 16'h39); expect_add(16'h39, 2'b11); cyc();
        chk("t3_done", state, 2'd3);
        chk("t3_cnt", entry_count, 6);
        drain("t3", 1'b0);

        // 4: largest post_count (15 truncates to 7), trigger sample with no valid bits
        filter_en = 1'b1; trig_mode = 2'b10; post_count = AW'(15);
        do_arm();
        e_n = 0;
        put(2'b00, 16'h50); expect_add(16'h50, 2'b00); cyc();
        chk("t4_post", state, 2'd2);
        trig_mode = 2'b11;
        for (int i = 1; i <= 7; i++) begin
            put(2'b11, 16'h50 + 16'(i)); expect_add(16'h50 + 16'(i), 2'b11); cyc();
            if (i == 6) chk("t4_post6", state, 2'd2);
        end
        chk("t4_done", state, 2'd3);
        chk("t4_cnt", entry_count, 8);
        chk("t4_wrap", wrapped, 1'b0);
        arm = 1'b1; cyc(); arm = 1'b0;
        chk("t4_arm_ign", state, 2'd3);
        // 5: random back-pressure on the same window
        drain("t5", 1'b1);

        // 6: abort (with simultaneous arm) in POST
        filter_en = 1'b0; trig_mode = 2'b10; post_count = 3'd5;
        do_arm();
        put(2'b11, 16'h60); cyc();
        put(2'b11, 16'h61); cyc();
        put(2'b11, 16'h62); cyc();
        chk("t6_post", state, 2'd2);
        chk("t6_cnt", entry_count, 3);
        abort = 1'b1; arm = 1'b1; cyc(); abort = 1'b0; arm = 1'b0;
        chk("t6_ab_state", state, 2'd0);
        chk("t6_ab_cnt", entry_count, 0);
        chk("t6_ab_vld", rd_valid, 1'b0);
        chk("t6_ab_wrap", wrapped, 1'b0);

        // post_count=0: trigger goes straight to DONE with one entry
        post_count = 3'd0;
        do_arm();
        e_n = 0;
        put(2'b10, 16'h70); expect_add(16'h70, 2'b10); cyc();
        chk("t7_done", state, 2'd3);
        chk("t7_cnt", entry_count, 1);
        drain("t7", 1'b0);

        // async reset mid-readout
        post_count = 3'd1;
        do_arm();
        put(2'b11, 16'h80); cyc();
        put(2'b11, 16'h81); cyc();
        chk("t8_done", state, 2'd3);
        chk("t8_cnt", entry_count, 2);
        rd_ready = 1'b1; cyc(); rd_ready = 1'b0;
        chk("t8_cnt1", entry_count, 1);
        chk("t8_dat", rd_data, mkdat(16'h81));
        #2 rst_n = 1'b0;
        #1;
        chk("t8_rst_state", state, 2'd0);
        chk("t8_rst_cnt", entry_count, 0);
        chk("t8_rst_vld", rd_valid, 1'b0);
        chk("t8_rst_last", rd_last, 1'b0);
        rst_n = 1'b1;
        cyc();
        chk("t8_post_rst", state, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
